// File: rtl/lc3b_types.sv
// Shared LC-3b types for the memory responder slice.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } lc3b_memresp_state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/lc3b_mem_responder_if.sv
// LC-3b single-port memory bus: initiator (master) and memory (slave) views.
interface lc3b_mem_responder_if;
    import lc3b_types::*;

    logic          mem_read;
    logic          mem_write;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_word      mem_rdata;
    logic          mem_resp;
    logic          protocol_err;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp, protocol_err
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp, protocol_err
    );

endinterface

// File: rtl/lc3b_word_ram.sv
// Word-organised 16-bit RAM: one byte-masked sync write port, one registered read port.
module lc3b_word_ram
    import lc3b_types::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  lc3b_mem_wmask     be,
    input  logic [ADDR_W-1:0] waddr,
    input  lc3b_word          wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output lc3b_word          rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    lc3b_word mem [DEPTH];
    lc3b_word rdata_q;
    lc3b_word rdata_d;

    // Read register holds its value between enabled reads.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (we && be[0]) begin
            mem[waddr][7:0] <= wdata[7:0];
        end
        if (we && be[1]) begin
            mem[waddr][15:8] <= wdata[15:8];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory-side responder: one request at a time, fixed latency, byte-masked writes.
module lc3b_mem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    lc3b_mem_responder_if.slave  bus
);

    lc3b_memresp_state_t state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                op_rd_q, op_rd_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    lc3b_word            wdata_q, wdata_d;
    lc3b_mem_wmask       be_q, be_d;
    logic                resp_q, resp_d;
    logic                err_q, err_d;
    logic                rvalid_q, rvalid_d;

    logic     req;
    logic     ram_re;
    logic     ram_we;
    lc3b_word ram_rdata;
    logic     unused_addr;

    assign req = bus.mem_read | bus.mem_write;
    assign unused_addr = ^{bus.mem_address[15:ADDR_W+1], bus.mem_address[0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_rd_d  = op_rd_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        resp_d   = 1'b0;
        err_d    = 1'b0;
        rvalid_d = rvalid_q;
        ram_re   = 1'b0;
        ram_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    op_rd_d = bus.mem_read;
                    idx_d   = bus.mem_address[ADDR_W:1];
                    wdata_d = bus.mem_wdata;
                    be_d    = bus.mem_byte_enable;
                    // Read wins a simultaneous read/write; flag the conflict.
                    err_d   = bus.mem_read & bus.mem_write;
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d  = RESP;
                    resp_d   = 1'b1;
                    ram_re   = op_rd_q & ~rst;
                    rvalid_d = rvalid_q | op_rd_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ram_we  = ~op_rd_q & ~rst;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_rd_q  <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            resp_q   <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_rd_q  <= op_rd_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            resp_q   <= resp_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
        end
    end

    lc3b_word_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (be_q),
        .waddr (idx_q),
        .wdata (wdata_q),
        .re    (ram_re),
        .raddr (idx_q),
        .rdata (ram_rdata)
    );

    // The RAM read register has no reset, so mask it until a read lands.
    assign bus.mem_rdata    = rvalid_q ? ram_rdata : '0;
    assign bus.mem_resp     = resp_q;
    assign bus.protocol_err = err_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Scoreboard bench for lc3b_mem_responder: directed transactions, decoupled monitor.
module tb_lc3b_mem_responder;

    localparam int LAT = 4;

    typedef struct {
        bit          is_err;
        bit          chk;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t expq[$];

    lc3b_mem_responder_if bus();

    lc3b_mem_responder #(
        .LATENCY (LAT),
        .ADDR_W  (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic mon_event(input bit is_err);
        exp_t e;
        total++;
        if (expq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s cyc=%0d", is_err ? "err" : "resp", cyc);
        end else begin
            e = expq.pop_front();
            if (e.is_err != is_err || e.cyc != cyc
                || (e.chk && bus.mem_rdata !== e.data)) begin
                bad++;
                $display("FAIL %s got kind=%0d cyc=%0d data=%h want kind=%0d cyc=%0d data=%h",
                         is_err ? "err" : "resp", is_err, cyc, bus.mem_rdata,
                         e.is_err, e.cyc, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.protocol_err === 1'b1) mon_event(1'b1);
        if (bus.mem_resp === 1'b1) mon_event(1'b0);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, req);
        end
    endtask

    task automatic idle_bus();
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = 16'h0;
        bus.mem_wdata       = 16'h0;
        bus.mem_byte_enable = 2'b00;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input logic [1:0] be);
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_address     = a;
        bus.mem_wdata       = d;
        bus.mem_byte_enable = be;
    endtask

    task automatic push(input bit is_err, input bit chk, input logic [15:0] d, input int c);
        exp_t e;
        e.is_err = is_err;
        e.chk    = chk;
        e.data   = d;
        e.cyc    = c;
        expq.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the edge that follows mem_resp.
    task automatic xact(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [1:0] be,
                        input logic [15:0] exp_data);
        int  c0;
        bit  seen;
        c0 = cyc;
        if (rd && wr) push(1'b1, 1'b0, 16'h0, c0 + 1);
        push(1'b0, rd, exp_data, c0 + LAT + 1);
        drive(rd, wr, a, d, be);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = (bus.mem_resp === 1'b1);
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL timeout addr=%h got=no_resp want=resp", a);
        end
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int c0;
        idle_bus();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp", {15'h0, bus.mem_resp}, 16'h0);
        check("rst_err", {15'h0, bus.protocol_err}, 16'h0);
        check("rst_rdata", bus.mem_rdata, 16'h0000);
        rst = 1'b0;
        idle_cycles(1);

        // 1: basic write then read
        xact(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0);
        xact(1'b1, 1'b0, 16'h0010, 16'h0, 2'b00, 16'hBEEF);
        idle_cycles(2);

        // 2: byte masks
        xact(1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, 16'h0);
        xact(1'b0, 1'b1, 16'h0020, 16'hAB00, 2'b10, 16'h0);
        check("rdata_hold", bus.mem_rdata, 16'hBEEF);
        xact(1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, 16'hAB34);
        xact(1'b0, 1'b1, 16'h0020, 16'h00CD, 2'b01, 16'h0);
        xact(1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, 16'hABCD);
        idle_cycles(1);

        // 3: back-to-back alternating write/read, 6 cycles apart
        xact(1'b0, 1'b1, 16'h0100, 16'h1111, 2'b11, 16'h0);
        xact(1'b1, 1'b0, 16'h0100, 16'h0, 2'b00, 16'h1111);
        xact(1'b0, 1'b1, 16'h0102, 16'h2222, 2'b11, 16'h0);
        xact(1'b1, 1'b0, 16'h0102, 16'h0, 2'b00, 16'h2222);
        xact(1'b0, 1'b1, 16'h0104, 16'hC3A5, 2'b11, 16'h0);
        xact(1'b1, 1'b0, 16'h0104, 16'h0, 2'b00, 16'hC3A5);
        xact(1'b0, 1'b1, 16'h0106, 16'h0F0F, 2'b11, 16'h0);
        xact(1'b1, 1'b0, 16'h0106, 16'h0, 2'b00, 16'h0F0F);
        idle_cycles(2);

        // 4a: read dropped after two BUSY cycles
        c0 = cyc;
        push(1'b1, 1'b0, 16'h0, c0 + 4);
        drive(1'b1, 1'b0, 16'h0020, 16'h0, 2'b00);
        idle_cycles(3);
        idle_bus();
        idle_cycles(8);
        xact(1'b1, 1'b0, 16'h0106, 16'h0, 2'b00, 16'h0F0F);

        // 4b: reset during a write's BUSY phase
        xact(1'b0, 1'b1, 16'h0030, 16'h6C6C, 2'b11, 16'h0);
        drive(1'b0, 1'b1, 16'h0030, 16'h1111, 2'b11);
        idle_cycles(3);
        rst = 1'b1;
        idle_bus();
        idle_cycles(1);
        rst = 1'b0;
        check("rst_mid_rdata", bus.mem_rdata, 16'h0000);
        idle_cycles(8);
        xact(1'b1, 1'b0, 16'h0030, 16'h0, 2'b00, 16'h6C6C);

        // 5: simultaneous read and write, read wins
        xact(1'b0, 1'b1, 16'h0040, 16'h5555, 2'b11, 16'h0);
        xact(1'b1, 1'b1, 16'h0040, 16'hFFFF, 2'b11, 16'h5555);
        check("both_rdata", bus.mem_rdata, 16'h5555);
        xact(1'b1, 1'b0, 16'h0040, 16'h0, 2'b00, 16'h5555);

        // 6: address wrap and empty byte mask
        xact(1'b0, 1'b1, 16'h0802, 16'h7777, 2'b11, 16'h0);
        xact(1'b1, 1'b0, 16'h0002, 16'h0, 2'b00, 16'h7777);
        xact(1'b0, 1'b1, 16'h0002, 16'hFFFF, 2'b00, 16'h0);
        xact(1'b1, 1'b0, 16'h0002, 16'h0, 2'b00, 16'h7777);

        idle_cycles(10);
        check("pending_expect", 16'(expq.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
